// File: rtl/cam_seq.sv
// rtl/cam_seq.sv - CAM command sequencer: write/search/invalidate with valid-qualified hits
// Drives an external CAM and qualifies its raw match with a per-entry valid bitmap.
module cam_seq #(
    parameter int NB_MEM    = 16,
    parameter int SIZE_ADDR = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [SIZE_ADDR-1:0] cmd_addr,
    input  logic [7:0]           cmd_data,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_hit,
    output logic [SIZE_ADDR-1:0] rsp_index,
    output logic                 cam_write,
    output logic                 cam_enable,
    output logic [SIZE_ADDR:0]   cam_addr,
    output logic [7:0]           cam_data,
    input  logic [SIZE_ADDR:0]   cam_out,
    input  logic                 cam_found,
    output logic [15:0]          search_cnt,
    output logic [15:0]          hit_cnt
);

    typedef enum logic [2:0] {IDLE, WRITE, SEARCH, WAIT, RESP} state_t;

    state_t                 state_q;
    logic                   cmd_ready_q;
    logic                   rsp_valid_q;
    logic                   rsp_hit_q;
    logic [SIZE_ADDR-1:0]   rsp_index_q;
    logic                   cam_write_q;
    logic                   cam_enable_q;
    logic [SIZE_ADDR:0]     cam_addr_q;
    logic [7:0]             cam_data_q;
    logic [SIZE_ADDR-1:0]   addr_q;
    logic [NB_MEM-1:0]      valid_q;
    logic [15:0]            search_cnt_q;
    logic [15:0]            hit_cnt_q;

    logic [SIZE_ADDR-1:0]   out_idx;
    logic                   hit_d;
    logic [SIZE_ADDR-1:0]   index_d;
    logic [15:0]            search_cnt_d;
    logic [15:0]            hit_cnt_d;
    logic                   unused_cam_out_msb;

    assign unused_cam_out_msb = cam_out[SIZE_ADDR];

    // The CAM itself never forgets a key; the valid bitmap is what makes a match real.
    always_comb begin
        out_idx      = cam_out[SIZE_ADDR-1:0];
        hit_d        = cam_found & valid_q[out_idx];
        index_d      = hit_d ? out_idx : '0;
        search_cnt_d = (search_cnt_q == 16'hFFFF) ? search_cnt_q : search_cnt_q + 16'd1;
        hit_cnt_d    = (hit_cnt_q == 16'hFFFF) ? hit_cnt_q : hit_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cmd_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_hit_q    <= 1'b0;
            rsp_index_q  <= '0;
            cam_write_q  <= 1'b0;
            cam_enable_q <= 1'b0;
            cam_addr_q   <= '0;
            cam_data_q   <= '0;
            addr_q       <= '0;
            valid_q      <= '0;
            search_cnt_q <= '0;
            hit_cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        addr_q <= cmd_addr;
                        case (cmd_op)
                            2'b00: begin
                                state_q     <= WRITE;
                                cmd_ready_q <= 1'b0;
                                cam_write_q <= 1'b1;
                                cam_addr_q  <= {1'b0, cmd_addr};
                                cam_data_q  <= cmd_data;
                            end
                            2'b01: begin
                                state_q      <= SEARCH;
                                cmd_ready_q  <= 1'b0;
                                cam_enable_q <= 1'b1;
                                cam_data_q   <= cmd_data;
                            end
                            2'b10:   valid_q[cmd_addr] <= 1'b0;
                            default: valid_q           <= '0;
                        endcase
                    end
                end
                WRITE: begin
                    cam_write_q     <= 1'b0;
                    cam_addr_q      <= '0;
                    cam_data_q      <= '0;
                    valid_q[addr_q] <= 1'b1;
                    cmd_ready_q     <= 1'b1;
                    state_q         <= IDLE;
                end
                SEARCH: begin
                    cam_enable_q <= 1'b0;
                    cam_data_q   <= '0;
                    state_q      <= WAIT;
                end
                WAIT: begin
                    rsp_hit_q    <= hit_d;
                    rsp_index_q  <= index_d;
                    rsp_valid_q  <= 1'b1;
                    search_cnt_q <= search_cnt_d;
                    if (hit_d) begin
                        hit_cnt_q <= hit_cnt_d;
                    end
                    state_q <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_hit_q   <= 1'b0;
                        rsp_index_q <= '0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_hit    = rsp_hit_q;
    assign rsp_index  = rsp_index_q;
    assign cam_write  = cam_write_q;
    assign cam_enable = cam_enable_q;
    assign cam_addr   = cam_addr_q;
    assign cam_data   = cam_data_q;
    assign search_cnt = search_cnt_q;
    assign hit_cnt    = hit_cnt_q;

endmodule
